// File: rtl/ticket_pkg.sv
// ticket_pkg
//   Shared definitions for the ticket dispense arbiter:
//   - one-hot FSM state encoding
//   - default lane count, watchdog length and fault counter width
//   - helper that derives the lane index width from the lane count
package ticket_pkg;

  localparam int NUM_LANES_DEF = 4;
  localparam int TIMEOUT_DEF   = 16;
  localparam int FCNT_W_DEF    = 8;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_START = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_FAIL  = 5'b10000
  } state_t;

  // Width of a lane index; never below 1 so a select vector always exists.
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_lane_picker.sv
// rr_lane_picker
//   Combinational round-robin selector. Scans lanes starting just after
//   the last served lane and wrapping around, returning the first lane
//   with an active request.
//   Ports:
//     i_req   [NUM_LANES-1:0]  per-lane request levels
//     i_last  [SEL_W-1:0]      index of the lane served most recently
//     o_valid                  at least one request is pending
//     o_sel   [SEL_W-1:0]      chosen lane (0 when o_valid is low)
module rr_lane_picker
  import ticket_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int SEL_W     = lane_idx_w(NUM_LANES_DEF)
) (
  input  logic [NUM_LANES-1:0] i_req,
  input  logic [SEL_W-1:0]     i_last,
  output logic                 o_valid,
  output logic [SEL_W-1:0]     o_sel
);

  logic [SEL_W-1:0] w_lane;

  // Walk from the farthest candidate (Last itself) back to the nearest
  // (Last+1); the last hit written is therefore the highest-priority one.
  always_comb begin
    o_valid = 1'b0;
    o_sel   = '0;
    w_lane  = '0;
    for (int i = NUM_LANES; i >= 1; i--) begin
      w_lane = SEL_W'((int'(i_last) + i) % NUM_LANES);
      if (i_req[w_lane]) begin
        o_valid = 1'b1;
        o_sel   = w_lane;
      end
    end
  end

endmodule

// File: rtl/ticket_dispense_arbiter.sv
// ticket_dispense_arbiter
//   Shares one ticket printer among NUM_LANES vending front-ends. A lane
//   is picked round-robin, the printer is started with a one-cycle pulse
//   and watched for done/fault with a watchdog, and the lane receives a
//   one-cycle Ack (ticket issued) or Refund (printer failed).
//   Ports:
//     i_clock          system clock, rising edge
//     i_clear          asynchronous active-high reset
//     i_req            per-lane dispense request (level)
//     o_grant          one-hot owner of the printer
//     o_ack            one-cycle ticket-issued pulse to the owner
//     o_refund         one-cycle printer-failed pulse to the owner
//     o_print_start    one-cycle printer start pulse
//     i_print_done     printer completion pulse
//     i_print_fault    printer error pulse
//     o_busy           high whenever the FSM is not idle
//     o_fault_cnt      saturating count of failed transactions
module ticket_dispense_arbiter
  import ticket_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int FCNT_W    = FCNT_W_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_clear,
  input  logic [NUM_LANES-1:0] i_req,
  output logic [NUM_LANES-1:0] o_grant,
  output logic [NUM_LANES-1:0] o_ack,
  output logic [NUM_LANES-1:0] o_refund,
  output logic                 o_print_start,
  input  logic                 i_print_done,
  input  logic                 i_print_fault,
  output logic                 o_busy,
  output logic [FCNT_W-1:0]    o_fault_cnt
);

  localparam int SEL_W = lane_idx_w(NUM_LANES);
  localparam int TMR_W = 8;

  state_t               r_state;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     r_last;
  logic [TMR_W-1:0]     r_timer;
  logic [FCNT_W-1:0]    r_fault_cnt;
  logic [NUM_LANES-1:0] r_grant;
  logic [NUM_LANES-1:0] r_ack;
  logic [NUM_LANES-1:0] r_refund;
  logic                 r_print_start;
  logic                 r_busy;

  logic                 w_valid;
  logic [SEL_W-1:0]     w_sel;
  logic [NUM_LANES-1:0] w_pick_onehot;

  rr_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .SEL_W     (SEL_W)
  ) u_picker (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_sel   (w_sel)
  );

  assign w_pick_onehot = NUM_LANES'(1) << w_sel;

  // Outputs are registered together with the state they belong to, so
  // they are a pure function of the registered state and selected lane.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state       <= ST_IDLE;
      r_sel         <= '0;
      r_last        <= SEL_W'(NUM_LANES - 1);
      r_timer       <= '0;
      r_fault_cnt   <= '0;
      r_grant       <= '0;
      r_ack         <= '0;
      r_refund      <= '0;
      r_print_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_print_start <= 1'b0;
      r_ack         <= '0;
      r_refund      <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state       <= ST_START;
            r_sel         <= w_sel;
            r_grant       <= w_pick_onehot;
            r_print_start <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        ST_START: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done takes precedence over a simultaneous fault.
          if (i_print_done) begin
            r_state <= ST_DONE;
            r_ack   <= r_grant;
          end else if (i_print_fault || (r_timer == TMR_W'(TIMEOUT - 1))) begin
            r_state  <= ST_FAIL;
            r_refund <= r_grant;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_DONE: begin
          r_last  <= r_sel;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_FAIL: begin
          if (r_fault_cnt != '1) begin
            r_fault_cnt <= r_fault_cnt + FCNT_W'(1);
          end
          r_last  <= r_sel;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_ack         = r_ack;
  assign o_refund      = r_refund;
  assign o_print_start = r_print_start;
  assign o_busy        = r_busy;
  assign o_fault_cnt   = r_fault_cnt;

endmodule

// File: tb/tb_ticket_dispense_arbiter.sv
module tb_ticket_dispense_arbiter;

  logic       clk;
  logic       i_clear;
  logic [3:0] i_req;
  logic [3:0] o_grant;
  logic [3:0] o_ack;
  logic [3:0] o_refund;
  logic       o_print_start;
  logic       i_print_done;
  logic       i_print_fault;
  logic       o_busy;
  logic [7:0] o_fault_cnt;

  int tests_run;
  int tests_failed;
  int ack_pulses;
  int refund_pulses;
  int onehot_err;

  ticket_dispense_arbiter #(
    .NUM_LANES (4),
    .TIMEOUT   (16),
    .FCNT_W    (8)
  ) dut (
    .i_clock       (clk),
    .i_clear       (i_clear),
    .i_req         (i_req),
    .o_grant       (o_grant),
    .o_ack         (o_ack),
    .o_refund      (o_refund),
    .o_print_start (o_print_start),
    .i_print_done  (i_print_done),
    .i_print_fault (i_print_fault),
    .o_busy        (o_busy),
    .o_fault_cnt   (o_fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping sampled mid-cycle.
  always @(negedge clk) begin
    if (|o_ack) ack_pulses++;
    if (|o_refund) refund_pulses++;
    if (!$onehot0(o_grant) || !$onehot0(o_ack) || !$onehot0(o_refund)) onehot_err++;
  end

  task automatic do_reset();
    i_clear = 1'b1;
    i_req = 4'b0000;
    i_print_done = 1'b0;
    i_print_fault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic wait_print_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_print_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_clear = 1'b1;
    i_req = 4'b1111;
    i_print_done = 1'b0;
    i_print_fault = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({o_grant, o_ack, o_refund} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_vectors: grant=%b ack=%b refund=%b, required all zero", o_grant, o_ack, o_refund);
    end
    tests_run++;
    if ({o_print_start, o_busy} !== 2'b00 || o_fault_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_status: ps=%b busy=%b fcnt=%0d, required 0 0 0", o_print_start, o_busy, o_fault_cnt);
    end
    i_req = 4'b0000;
    i_clear = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_single_lane();
    do_reset();
    i_req = 4'b0001;
    @(negedge clk);
    tests_run++;
    if (o_grant !== 4'b0001 || o_print_start !== 1'b1 || o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_start: grant=%b ps=%b busy=%b, required 0001 1 1", o_grant, o_print_start, o_busy);
    end
    @(negedge clk);
    tests_run++;
    if (o_print_start !== 1'b0 || o_grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_ps_pulse: ps=%b grant=%b, required 0 0001", o_print_start, o_grant);
    end
    @(negedge clk);
    i_print_done = 1'b1;
    @(negedge clk);
    i_print_done = 1'b0;
    i_req = 4'b0000;
    tests_run++;
    if (o_ack !== 4'b0001 || o_refund !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_ack: ack=%b refund=%b, required 0001 0000", o_ack, o_refund);
    end
    @(negedge clk);
    tests_run++;
    if (o_ack !== 4'b0000 || o_busy !== 1'b0 || o_grant !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_after: ack=%b busy=%b grant=%b, required 0000 0 0000", o_ack, o_busy, o_grant);
    end
    $display("[TB] single lane transaction done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [4];
    bit ok;
    int acks_before;
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b1000;
    exp_order[3] = 4'b0001;
    do_reset();
    acks_before = ack_pulses;
    i_req = 4'b1011;
    for (int t = 0; t < 4; t++) begin
      wait_print_start(ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL rr_start_timeout: txn %0d no PrintStart within 20 cycles", t);
      end else begin
        tests_run++;
        if (o_grant !== exp_order[t]) begin
          tests_failed++;
          $display("FAIL rr_grant: txn %0d grant=%b, required %b", t, o_grant, exp_order[t]);
        end
        @(negedge clk);
        i_print_done = 1'b1;
        @(negedge clk);
        i_print_done = 1'b0;
        if (t == 3) i_req = 4'b0000;
        tests_run++;
        if (o_ack !== exp_order[t]) begin
          tests_failed++;
          $display("FAIL rr_ack: txn %0d ack=%b, required %b", t, o_ack, exp_order[t]);
        end
        $display("[TB] rr txn %0d grant=%b ack=%b", t, o_grant, o_ack);
      end
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (ack_pulses - acks_before !== 4) begin
      tests_failed++;
      $display("FAIL rr_ack_count: got %0d ack pulses, required 4", ack_pulses - acks_before);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int early;
    int acks_before;
    do_reset();
    acks_before = ack_pulses;
    i_req = 4'b0100;
    wait_print_start(ok);
    i_req = 4'b0000;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL to_start_timeout: no PrintStart");
    end
    early = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (o_refund !== 4'b0000 || o_busy !== 1'b1) early++;
    end
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("FAIL to_wait_span: %0d bad WAIT cycles, required 0", early);
    end
    @(negedge clk);
    tests_run++;
    if (o_refund !== 4'b0100 || o_grant !== 4'b0100) begin
      tests_failed++;
      $display("FAIL to_refund: refund=%b grant=%b, required 0100 0100", o_refund, o_grant);
    end
    @(negedge clk);
    tests_run++;
    if (o_refund !== 4'b0000 || o_fault_cnt !== 8'd1 || ack_pulses !== acks_before) begin
      tests_failed++;
      $display("FAIL to_after: refund=%b fcnt=%0d acks=%0d, required 0000 1 0", o_refund, o_fault_cnt, ack_pulses - acks_before);
    end
    $display("[TB] timeout refund fcnt=%0d", o_fault_cnt);
  endtask

  task automatic test_collision();
    bit ok;
    do_reset();
    i_req = 4'b0001;
    wait_print_start(ok);
    i_req = 4'b0000;
    @(negedge clk);
    i_print_done = 1'b1;
    i_print_fault = 1'b1;
    @(negedge clk);
    i_print_done = 1'b0;
    i_print_fault = 1'b0;
    tests_run++;
    if (o_ack !== 4'b0001 || o_refund !== 4'b0000) begin
      tests_failed++;
      $display("FAIL coll_ack: ack=%b refund=%b, required 0001 0000", o_ack, o_refund);
    end
    @(negedge clk);
    tests_run++;
    if (o_fault_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL coll_fcnt: fcnt=%0d, required 0", o_fault_cnt);
    end
    $display("[TB] collision ack=%b fcnt=%0d", o_ack, o_fault_cnt);
    i_req = 4'b0010;
    wait_print_start(ok);
    i_req = 4'b0000;
    @(negedge clk);
    i_print_fault = 1'b1;
    @(negedge clk);
    i_print_fault = 1'b0;
    tests_run++;
    if (o_refund !== 4'b0010 || o_ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL fault_refund: refund=%b ack=%b, required 0010 0000", o_refund, o_ack);
    end
    @(negedge clk);
    tests_run++;
    if (o_fault_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL fault_fcnt: fcnt=%0d, required 1", o_fault_cnt);
    end
    $display("[TB] lone fault refund fcnt=%0d", o_fault_cnt);
  endtask

  task automatic test_clear_mid_wait();
    bit ok;
    int acks_before;
    int refunds_before;
    do_reset();
    i_req = 4'b0010;
    wait_print_start(ok);
    @(negedge clk);
    @(negedge clk);
    acks_before = ack_pulses;
    refunds_before = refund_pulses;
    i_clear = 1'b1;
    #1;
    tests_run++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_async: grant=%b busy=%b, required 0000 0", o_grant, o_busy);
    end
    @(negedge clk);
    i_print_done = 1'b1;
    @(negedge clk);
    i_print_done = 1'b0;
    i_clear = 1'b0;
    i_req = 4'b0011;
    @(negedge clk);
    tests_run++;
    if (o_grant !== 4'b0001 || o_print_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_priority: grant=%b ps=%b, required 0001 1", o_grant, o_print_start);
    end
    tests_run++;
    if (ack_pulses !== acks_before || refund_pulses !== refunds_before) begin
      tests_failed++;
      $display("FAIL clear_no_pulse: acks=%0d refunds=%0d, required 0 0", ack_pulses - acks_before, refund_pulses - refunds_before);
    end
    $display("[TB] clear mid-wait regrant=%b", o_grant);
    i_req = 4'b0000;
  endtask

  task automatic test_req_drop();
    bit ok;
    do_reset();
    i_req = 4'b1000;
    wait_print_start(ok);
    @(negedge clk);
    i_req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    i_print_done = 1'b1;
    @(negedge clk);
    i_print_done = 1'b0;
    tests_run++;
    if (o_ack !== 4'b1000) begin
      tests_failed++;
      $display("FAIL req_drop_ack: ack=%b, required 1000", o_ack);
    end
    $display("[TB] req drop ack=%b", o_ack);
  endtask

  task automatic test_saturation();
    bit ok;
    int misses;
    do_reset();
    misses = 0;
    i_req = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      wait_print_start(ok);
      if (!ok) misses++;
      if (i == 200) begin
        tests_run++;
        if (o_fault_cnt !== 8'd200) begin
          tests_failed++;
          $display("FAIL sat_mid: fcnt=%0d, required 200", o_fault_cnt);
        end
      end
      @(negedge clk);
      i_print_fault = 1'b1;
      @(negedge clk);
      i_print_fault = 1'b0;
    end
    i_req = 4'b0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if (misses !== 0) begin
      tests_failed++;
      $display("FAIL sat_start_timeout: %0d transactions without PrintStart", misses);
    end
    tests_run++;
    if (o_fault_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_final: fcnt=%0d, required 255", o_fault_cnt);
    end
    $display("[TB] saturation fcnt=%0d", o_fault_cnt);
    do_reset();
    tests_run++;
    if (o_fault_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL sat_clear: fcnt=%0d, required 0", o_fault_cnt);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    ack_pulses = 0;
    refund_pulses = 0;
    onehot_err = 0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_timeout();
    test_collision();
    test_clear_mid_wait();
    test_req_drop();
    test_saturation();
    tests_run++;
    if (onehot_err !== 0) begin
      tests_failed++;
      $display("FAIL onehot_outputs: %0d multi-lane cycles, required 0", onehot_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
